// File: rtl/msx_megarom_mapper.sv
// MSX cartridge MegaROM bank mapper. Decodes Z80 slot writes into four 8 KB
// window bank registers and drives the upper ROM address.
// Supported schemes: Konami, Konami-SCC, ASCII8 and ASCII16.
// The scheme comes from the board switches and is latched while RESET is high.
// Optional feature macro: KONAMI_SCC_EN.
//   Defined: mode 1 uses the Konami-SCC register map, and the scc_sel flag exists.
//   Undefined: mode 1 behaves exactly like mode 0.
//
// state   | meaning
// ST_IDLE | waiting for a fresh qualified write strobe
// ST_HOLD | write committed, waiting for the strobe to end
module msx_megarom_mapper #(
  parameter int ROMA_MSB     = 18,
  parameter int MODE_DEFAULT = 0
) (
  input  logic               SLOTCLK,
  input  logic               RESET,
  input  logic [15:11]       A,
  input  logic [7:0]         D,
  input  logic               EXSLTSL,
  input  logic               RD,
  input  logic               WR,
  input  logic               MREQ,
  input  logic               IORQ,
  input  logic               M1,
  input  logic               RFSH,
  input  logic [1:0]         MODE,
  input  logic               MODE_OVR,
  output logic [ROMA_MSB:12] ROMA,
  output logic               ROMOE
);

  localparam int          BANK_W     = ROMA_MSB - 12;
  localparam logic [1:0]  MODE_DEF_L = 2'(MODE_DEFAULT);

  typedef enum logic {ST_IDLE, ST_HOLD} state_t;

  state_t              state;
  logic                wq;
  logic                wq_r;
  logic [1:0]          mode_r;
  logic [1:0]          mode_eff;
  logic [BANK_W-1:0]   bank [4];
  logic [3:0]          wr_en;
  logic [BANK_W-1:0]   wr_val [4];
  logic [BANK_W-1:0]   d_bank;
  logic [BANK_W-1:0]   d_even;
  logic                unused_in;

  assign wq       = ~EXSLTSL & ~MREQ & ~WR & IORQ & RFSH;
  assign mode_eff = MODE_OVR ? MODE_DEF_L : MODE;
  assign d_bank   = D[BANK_W-1:0];
  assign d_even   = {D[BANK_W-2:0], 1'b0};
  assign unused_in = ^{M1, D};

  // Register the write qualifier every cycle, including during reset.
  // A strobe that is still low when reset ends therefore is not seen as a new write.
  always_ff @(posedge SLOTCLK) begin
    wq_r <= wq;
  end

  // Decode the current address/data into per-window write enables for the latched mode
  always_comb begin
    wr_en = 4'b0000;
    for (int i = 0; i < 4; i++) wr_val[i] = d_bank;
    case (mode_r)
      2'd2: begin
        if (A[15:13] == 3'b011) wr_en[A[12:11]] = 1'b1;
      end
      2'd3: begin
        if (A == 5'b01100) begin
          wr_en[1:0] = 2'b11;
          wr_val[0]  = d_even;
          wr_val[1]  = d_even | BANK_W'(1);
        end else if (A == 5'b01110) begin
          wr_en[3:2] = 2'b11;
          wr_val[2]  = d_even;
          wr_val[3]  = d_even | BANK_W'(1);
        end
      end
`ifdef KONAMI_SCC_EN
      2'd1: begin
        case (A)
          5'b01010: wr_en[0] = 1'b1;
          5'b01110: wr_en[1] = 1'b1;
          5'b10010: wr_en[2] = 1'b1;
          5'b10110: wr_en[3] = 1'b1;
          default:  wr_en    = 4'b0000;
        endcase
      end
`endif
      default: begin
        case (A[15:13])
          3'b011:  wr_en[1] = 1'b1;
          3'b100:  wr_en[2] = 1'b1;
          3'b101:  wr_en[3] = 1'b1;
          default: wr_en    = 4'b0000;
        endcase
      end
    endcase
  end

`ifdef KONAMI_SCC_EN
  logic scc_sel;
  logic unused_scc;
  assign unused_scc = scc_sel;

  // SCC sound-chip select flag, updated by the bank-2 register write
  always_ff @(posedge SLOTCLK) begin
    if (RESET) begin
      scc_sel <= 1'b0;
    end else if (state == ST_IDLE && wq && !wq_r && mode_r == 2'd1 && A == 5'b10010) begin
      scc_sel <= (D[5:0] == 6'h3F);
    end
  end
`endif

  // Write FSM and bank registers: commit once per strobe; reset restores the mode's bank layout
  always_ff @(posedge SLOTCLK) begin
    if (RESET) begin
      state  <= ST_IDLE;
      mode_r <= mode_eff;
      case (mode_eff)
        2'd2: begin
          bank[0] <= '0;
          bank[1] <= '0;
          bank[2] <= '0;
          bank[3] <= '0;
        end
        2'd3: begin
          bank[0] <= '0;
          bank[1] <= BANK_W'(1);
          bank[2] <= '0;
          bank[3] <= BANK_W'(1);
        end
        default: begin
          bank[0] <= '0;
          bank[1] <= BANK_W'(1);
          bank[2] <= BANK_W'(2);
          bank[3] <= BANK_W'(3);
        end
      endcase
    end else begin
      case (state)
        ST_IDLE: begin
          if (wq && !wq_r) begin
            state <= ST_HOLD;
            for (int i = 0; i < 4; i++) begin
              if (wr_en[i]) bank[i] <= wr_val[i];
            end
          end
        end
        ST_HOLD: begin
          if (!wq) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Windows: {A15,A13} selects the bank; pages 0 and 3 mirror pages 1 and 2
  always_comb begin
    ROMA  = {bank[{A[15], A[13]}], A[12]};
    ROMOE = MREQ | RD | EXSLTSL;
  end

endmodule

// File: tb/tb_msx_megarom_mapper.sv
// Testbench for msx_megarom_mapper: directed cases plus randomized bus traffic.
// The reference model applies address-range rules directly; a monitor checks read cycles.
module tb_msx_megarom_mapper;

  localparam int RM = 18;
  localparam int NB = 1 << (RM - 12);

  logic           SLOTCLK = 1'b0;
  logic           RESET;
  logic [15:11]   A;
  logic [7:0]     D;
  logic           EXSLTSL, RD, WR, MREQ, IORQ, M1, RFSH;
  logic [1:0]     MODE;
  logic           MODE_OVR;
  logic [RM:12]   ROMA;
  logic           ROMOE;

  msx_megarom_mapper #(.ROMA_MSB(RM), .MODE_DEFAULT(0)) dut (
    .SLOTCLK(SLOTCLK), .RESET(RESET), .A(A), .D(D), .EXSLTSL(EXSLTSL),
    .RD(RD), .WR(WR), .MREQ(MREQ), .IORQ(IORQ), .M1(M1), .RFSH(RFSH),
    .MODE(MODE), .MODE_OVR(MODE_OVR), .ROMA(ROMA), .ROMOE(ROMOE)
  );

  always #5 SLOTCLK = ~SLOTCLK;

  typedef struct { int exp; int addr; } exp_t;
  exp_t exp_q[$];
  int   applied    = 0;
  int   miscompares = 0;

  // Reference model state
  int mdl_mode;
  int mdl_bank[4];
  int win_of_page[8] = '{0, 1, 0, 1, 2, 3, 2, 3};

  function automatic void mdl_reset(input int m);
    mdl_mode = m;
    case (m)
      2: mdl_bank = '{0, 0, 0, 0};
      3: mdl_bank = '{0, 1, 0, 1};
      default: mdl_bank = '{0, 1, 2, 3};
    endcase
  endfunction

  function automatic bit in_rng(input int a, input int lo, input int hi);
    return (a >= lo) && (a < hi);
  endfunction

  function automatic void mdl_write(input int addr, input int d);
    int dm;
    bit scc;
    dm = d % NB;
`ifdef KONAMI_SCC_EN
    scc = (mdl_mode == 1);
`else
    scc = 1'b0;
`endif
    if (scc) begin
      if (in_rng(addr, 'h5000, 'h5800)) mdl_bank[0] = dm;
      if (in_rng(addr, 'h7000, 'h7800)) mdl_bank[1] = dm;
      if (in_rng(addr, 'h9000, 'h9800)) mdl_bank[2] = dm;
      if (in_rng(addr, 'hB000, 'hB800)) mdl_bank[3] = dm;
    end else if (mdl_mode == 2) begin
      if (in_rng(addr, 'h6000, 'h8000)) mdl_bank[(addr - 'h6000) / 'h800] = dm;
    end else if (mdl_mode == 3) begin
      if (in_rng(addr, 'h6000, 'h6800)) begin
        mdl_bank[0] = (2 * d) % NB;
        mdl_bank[1] = (2 * d + 1) % NB;
      end
      if (in_rng(addr, 'h7000, 'h7800)) begin
        mdl_bank[2] = (2 * d) % NB;
        mdl_bank[3] = (2 * d + 1) % NB;
      end
    end else begin
      if (in_rng(addr, 'h6000, 'h8000)) mdl_bank[1] = dm;
      if (in_rng(addr, 'h8000, 'hA000)) mdl_bank[2] = dm;
      if (in_rng(addr, 'hA000, 'hC000)) mdl_bank[3] = dm;
    end
  endfunction

  function automatic int mdl_roma(input int addr);
    return mdl_bank[win_of_page[addr / 'h2000]] * 2 + ((addr / 'h1000) % 2);
  endfunction

  task automatic bus_idle();
    EXSLTSL = 1'b1; RD = 1'b1; WR = 1'b1; MREQ = 1'b1;
    IORQ = 1'b1; M1 = 1'b1; RFSH = 1'b1;
  endtask

  task automatic do_reset(input int m, input bit ovr);
    @(posedge SLOTCLK); #1;
    bus_idle();
    RESET = 1'b1; MODE = 2'(m); MODE_OVR = ovr;
    repeat (2) @(posedge SLOTCLK);
    #1 RESET = 1'b0;
    mdl_reset(ovr ? 0 : m);
  endtask

  // kind: 0 qualified, 1 RFSH low, 2 IORQ low, 3 slot not selected
  task automatic do_write(input int addr, input int d1, input int d2, input int hold, input int kind);
    @(posedge SLOTCLK); #1;
    A = 5'(addr >> 11); D = 8'(d1);
    EXSLTSL = (kind == 3); MREQ = 1'b0; WR = 1'b0;
    RFSH = (kind != 1); IORQ = (kind != 2);
    if (kind == 0) mdl_write(addr, d1);
    @(posedge SLOTCLK); #1;
    D = 8'(d2);
    repeat (hold - 1) @(posedge SLOTCLK);
    #1 bus_idle();
  endtask

  task automatic do_read(input int addr);
    exp_t e;
    @(posedge SLOTCLK); #1;
    A = 5'(addr >> 11); D = 8'h00;
    EXSLTSL = 1'b0; MREQ = 1'b0; RD = 1'b0;
    e.exp = mdl_roma(addr); e.addr = addr;
    exp_q.push_back(e);
    @(posedge SLOTCLK); #1 bus_idle();
  endtask

  task automatic read_all_windows();
    do_read('h4000); do_read('h6000); do_read('h8000); do_read('hA000);
  endtask

  // Monitor: every active ROM read cycle is matched against the oldest expectation
  always @(negedge SLOTCLK) begin
    if (ROMOE === 1'b0) begin
      applied++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL romoe_spurious: ROMOE low with A=%h, required high", A);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (ROMA !== (RM-11)'(e.exp)) begin
          miscompares++;
          $display("FAIL roma@%h: got %h, required %h", e.addr[15:0], ROMA, e.exp);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_idle();
    A = '0; D = '0; RESET = 1'b1; MODE = 2'd0; MODE_OVR = 1'b0;
    mdl_reset(0);

    // Reset values in Konami mode, including mirrored pages
    do_reset(0, 1'b0);
    read_all_windows();
    do_read('h0000); do_read('hE000); do_read('h5000);

    // ROMOE only when MREQ, RD and EXSLTSL are all low
    for (int c = 0; c < 8; c++) begin
      exp_t e;
      @(posedge SLOTCLK); #1;
      A = 5'b01000;
      MREQ = c[0]; RD = c[1]; EXSLTSL = c[2];
      if (c == 0) begin
        e.exp = mdl_roma('h4000); e.addr = 'h4000;
        exp_q.push_back(e);
      end
      @(posedge SLOTCLK); #1 bus_idle();
    end

    // Konami: bank0 write ignored, others take effect
    do_write('h4000, 'h22, 'h22, 1, 0);
    do_write('h6000, 'h11, 'h11, 1, 0);
    do_write('hA800, 'h2A, 'h2A, 2, 0);
    read_all_windows();

    // ASCII8 directed
    do_reset(2, 1'b0);
    read_all_windows();
    do_write('h6800, 'h05, 'h05, 1, 0);
    do_read('h6000);
    do_write('h7800, 'h1F, 'h1F, 1, 0);
    do_read('hA000);
    do_write('h6000, 'hFF, 'hFF, 1, 0);
    do_read('h4000);

    // MODE change without reset is ignored
    MODE = 2'd0;
    do_write('h6000, 'h05, 'h05, 1, 0);
    do_read('h4000);

    // Disqualified writes
    do_write('h6000, 'h09, 'h09, 1, 1);
    do_write('h6000, 'h0A, 'h0A, 1, 2);
    do_write('h6000, 'h0B, 'h0B, 1, 3);
    do_read('h4000);

    // ASCII16 directed
    do_reset(3, 1'b0);
    read_all_windows();
    do_write('h7000, 'h03, 'h03, 1, 0);
    do_read('h8000); do_read('hA000);
    do_write('h6800, 'h07, 'h07, 1, 0);
    read_all_windows();

    // Long strobe with changing data commits once, first value
    do_reset(2, 1'b0);
    do_write('h6000, 'h01, 'h02, 4, 0);
    do_read('h4000);

    // Reset during HOLD; strobe still low after reset must not commit
    @(posedge SLOTCLK); #1;
    A = 5'b01101; D = 8'h11; EXSLTSL = 1'b0; MREQ = 1'b0; WR = 1'b0;
    mdl_write('h6800, 'h11);
    repeat (2) @(posedge SLOTCLK);
    #1 RESET = 1'b1;
    @(posedge SLOTCLK); #1 RESET = 1'b0;
    mdl_reset(2);
    D = 8'h22;
    repeat (3) @(posedge SLOTCLK);
    #1 bus_idle();
    read_all_windows();

    // MODE_OVR selects the default mode (Konami)
    do_reset(2, 1'b1);
    read_all_windows();

    // Mode 1: SCC map when enabled, else Konami behaviour
    do_reset(1, 1'b0);
    do_write('h5000, 'h09, 'h09, 1, 0);
    do_write('h7000, 'h0C, 'h0C, 1, 0);
    do_write('h9000, 'h3F, 'h3F, 1, 0);
    read_all_windows();

    // Randomized traffic in every mode
    for (int m = 0; m < 4; m++) begin
      do_reset(m, 1'b0);
      for (int k = 0; k < 60; k++) begin
        if ($urandom_range(0, 1) == 0) begin
          int kind;
          kind = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 3)) : 0;
          do_write(int'($urandom_range(8, 23)) * 'h800, int'($urandom_range(0, 255)),
                   int'($urandom_range(0, 255)), int'($urandom_range(1, 3)), kind);
        end else begin
          do_read(int'($urandom_range(0, 31)) * 'h800);
        end
      end
    end

    repeat (4) @(posedge SLOTCLK);
    applied++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL pending_reads: %0d expected reads never seen, required 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
